program_loader: RTL

Writer side of the processor's program-memory interface: receives a byte stream over a valid/ready handshake, assembles 26-bit instruction words and writes them into instruction RAM at consecutive addresses from 0. While loading, it holds the processor's program counter. At the end of the frame it checks a frame checksum and reports done or error. It sits between the host byte link and the write port of the program memory that the program counter reads.

---
 rtl/procesor_pkg.sv | 18 +
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader_word_assembler.sv | 46 ++++
 rtl/program_loader.sv | 124 ++++++++++++
 4 files changed

// File: rtl/procesor_pkg.sv
// Shared processor constants and the program-loader state type.
// The instruction decoder and the program memory use the same width constants.
package procesor_pkg;

  localparam int unsigned INS_WIDTH = 26;
  localparam int unsigned PC_WIDTH  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StDone,
    StError
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and program-RAM write bundle of the program loader.
//   master: host side; drives byte_in/byte_valid and observes ready and the RAM write port.
//   slave : loader side; accepts bytes and drives the RAM write port.
interface program_loader_if
  import procesor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PC_WIDTH,
  parameter int unsigned INS_WIDTH  = procesor_pkg::INS_WIDTH
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [INS_WIDTH-1:0]  prog_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, prog_we, prog_addr, prog_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, prog_we, prog_addr, prog_data
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four accepted bytes little-endian into one instruction word.
//   CLK, RST     : clock, asynchronous active-high reset
//   clear_i      : restart byte position at b0
//   accept_i     : byte_i is taken this cycle
//   word_done_o  : combinational pulse on acceptance of b3
//   word_o       : {b3,b2,b1,b0} truncated to the instruction width, valid with word_done_o
module word_assembler
  import procesor_pkg::*;
#(
  parameter int unsigned InsWidth = INS_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic [7:0]          byte_i,
  output logic                word_done_o,
  output logic [InsWidth-1:0] word_o
);

  logic [1:0]  cnt_q;
  // b3 is used straight from the input, so only b0..b2 need storing.
  logic [23:0] shift_q;
  logic [31:0] full;
  logic        unused_hi;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear_i) begin
      cnt_q <= 2'd0;
    end else if (accept_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  always_comb begin
    full        = {byte_i, shift_q};
    word_done_o = accept_i && (cnt_q == 2'd3);
    word_o      = full[InsWidth-1:0];
    unused_hi   = ^full[31:InsWidth];
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream into program RAM and holds the CPU while doing so.
//   CLK, RST      : clock, asynchronous active-high reset
//   start         : arm pulse, honoured only in IDLE/DONE/ERROR
//   bus           : byte handshake in, program-RAM write port out
//   cpu_hold      : PC hold, high while loading and after a checksum error
//   busy          : frame in progress
//   done / error  : result of the last frame (levels)
//   words_loaded  : words written in the current or last frame
module program_loader
  import procesor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PC_WIDTH,
  parameter int unsigned INS_WIDTH  = procesor_pkg::INS_WIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  loader_state_t         state_q, state_d;
  logic                  hs, start_ok, last_word;
  logic [15:0]           len_q, words_q;
  logic [7:0]            xor_q;
  logic                  prog_we_q;
  logic [ADDR_WIDTH-1:0] prog_addr_q;
  logic [INS_WIDTH-1:0]  prog_data_q;
  logic                  word_done;
  logic [INS_WIDTH-1:0]  word;

  word_assembler #(
    .InsWidth (INS_WIDTH)
  ) u_word_assembler (
    .CLK         (CLK),
    .RST         (RST),
    .clear_i     (start_ok),
    .accept_i    (hs && (state_q == StData)),
    .byte_i      (bus.byte_in),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    start_ok  = 1'b0;
    hs        = 1'b0;
    last_word = (words_q + 16'd1) == len_q;

    unique case (state_q)
      StLenLo, StLenHi, StData, StChk: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      StError: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase

    bus.byte_ready = busy;
    hs             = bus.byte_valid && busy;
    start_ok       = start && !busy;

    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StLenLo;
      StLenLo: if (hs) state_d = StLenHi;
      StLenHi: if (hs) state_d = ({bus.byte_in, len_q[7:0]} != 16'd0) ? StData : StChk;
      StData:  if (word_done && last_word) state_d = StChk;
      StChk:   if (hs) state_d = (bus.byte_in == xor_q) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q       <= 16'd0;
      words_q     <= 16'd0;
      xor_q       <= 8'd0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
    end else begin
      prog_we_q <= word_done;
      if (word_done) begin
        prog_addr_q <= ADDR_WIDTH'(words_q);
        prog_data_q <= word;
        words_q     <= words_q + 16'd1;
      end
      if (hs && (state_q == StLenLo)) len_q[7:0]  <= bus.byte_in;
      if (hs && (state_q == StLenHi)) len_q[15:8] <= bus.byte_in;
      // The checksum byte itself is compared, not folded in.
      if (hs && (state_q != StChk)) xor_q <= xor_q ^ bus.byte_in;
      if (start_ok) begin
        xor_q   <= 8'd0;
        words_q <= 16'd0;
        len_q   <= 16'd0;
      end
    end
  end

  always_comb begin
    bus.prog_we   = prog_we_q;
    bus.prog_addr = prog_addr_q;
    bus.prog_data = prog_data_q;
    words_loaded  = words_q;
  end

endmodule
